// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// An entry carries the fetch address alongside the returned instruction word.
package instruction_fetch_queue_pkg;

  localparam int unsigned DefaultDepth   = 4;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  typedef enum logic [0:0] {
    StRun,
    StFlush
  } ifq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/instruction_fifo.sv
// Synchronous FIFO of fetch entries with single-cycle flush.
// Flush wins over push and pop in the same cycle.
module instruction_fifo
  import instruction_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  ifq_entry_t               push_data,
  input  logic                     pop,
  input  logic                     flush,
  output ifq_entry_t               head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  ifq_entry_t     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != (AW+1)'(DEPTH)) && !flush;
    do_pop   = pop && (count_q != '0) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Sequential instruction fetcher: issues addresses, queues in-order responses
// for decode, and flushes outstanding responses on a redirect.
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = DefaultDepth,
  parameter int unsigned PC_INCREMENT = 4,
  parameter logic [31:0] RESET_PC     = DefaultResetPc
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ifq_state_e    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  ifq_entry_t    fifo_head, push_entry;
  logic          fifo_empty, req_fire, rsp_fire, push, pop;

  // rsp_pc tracks the address of the oldest non-discarded outstanding request;
  // requests since the last redirect are contiguous, so a counter suffices.
  always_comb begin
    occupancy     = {1'b0, fifo_count} + {1'b0, inflight_q};
    mem_req_valid = !reset && (state_q == StRun) && !redirect_valid &&
                    (occupancy < (CW+1)'(DEPTH));
    mem_req_addr  = fetch_pc_q;
    req_fire      = mem_req_valid && mem_req_ready;
    rsp_fire      = mem_rsp_valid && (inflight_q != '0);
    push          = rsp_fire && (state_q == StRun) && !redirect_valid;
    instr_valid   = (state_q == StRun) && !redirect_valid && !fifo_empty;
    pop           = instr_valid && instr_ready;
    instr         = fifo_empty ? '0 : fifo_head.instr;
    instr_pc      = fifo_empty ? '0 : fifo_head.pc;
    push_entry    = '{pc: rsp_pc_q, instr: mem_rsp_data};

    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'(PC_INCREMENT);
      if (push)     rsp_pc_d   = rsp_pc_q + 32'(PC_INCREMENT);
    end

    state_d = state_q;
    case (state_q)
      StRun:   if (redirect_valid) state_d = (inflight_d != '0) ? StFlush : StRun;
      StFlush: if (!redirect_valid && inflight_d == '0) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
    end
  end

  instruction_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue with an in-order memory model
// whose responses are released by the stimulus one per cycle.
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_req, n_pop;
  logic [31:0] exp_req_pc, exp_instr_pc;
  logic [31:0] pend[$];
  logic        last_req_valid, last_instr_valid;
  logic [31:0] last_req_addr;

  always #5 clk = ~clk;

  instruction_fetch_queue #(
    .DEPTH       (4),
    .PC_INCREMENT(4),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    pend.delete();
    exp_req_pc = 32'h0; exp_instr_pc = 32'h0; n_req = 0; n_pop = 0;
    @(posedge clk); #1;
    check_eq({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    check_eq({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check_eq({tag, "_instr"}, instr, 32'd0);
    check_eq({tag, "_instr_pc"}, instr_pc, 32'd0);
    reset = 1'b0;
  endtask

  // One clock: drive inputs, optionally return the oldest outstanding word,
  // score any request/instruction handshake, then advance past the edge.
  task automatic cycle(input logic rdy, input logic irdy, input logic rsp,
                       input logic redir, input logic [31:0] rpc);
    mem_req_ready = rdy; instr_ready = irdy; redirect_valid = redir; redirect_pc = rpc;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    if (rsp && pend.size() > 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(pend.pop_front());
    end
    #1;
    last_req_valid = mem_req_valid; last_instr_valid = instr_valid;
    last_req_addr  = mem_req_addr;
    if (mem_req_valid && rdy) begin
      check_eq("req_addr", mem_req_addr, exp_req_pc);
      exp_req_pc += 32'd4;
      n_req++;
      pend.push_back(mem_req_addr);
    end
    if (instr_valid && irdy) begin
      check_eq("instr_pc", instr_pc, exp_instr_pc);
      check_eq("instr", instr, mem_word(exp_instr_pc));
      exp_instr_pc += 32'd4;
      n_pop++;
    end
    if (redir) begin
      exp_req_pc = rpc;
      exp_instr_pc = rpc;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Streaming: 1-cycle memory, decode always ready.
    apply_reset("rst0");
    cycle(1, 1, 1, 0, 0);
    check_eq("first_req_valid", 32'(last_req_valid), 32'd1);
    for (int i = 0; i < 9; i++) cycle(1, 1, 1, 0, 0);
    check_eq("stream_n_req", n_req, 10);
    check_eq("stream_n_pop", n_pop, 8);

    // Decode stalled: queue fills to DEPTH, then drains 0..12.
    apply_reset("rst1");
    for (int i = 0; i < 8; i++) cycle(1, 0, 1, 0, 0);
    check_eq("stall_n_req", n_req, 4);
    check_eq("stall_req_valid", 32'(last_req_valid), 32'd0);
    check_eq("stall_head_pc", instr_pc, 32'h0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0, 0);
    check_eq("drain_n_pop", n_pop, 4);
    check_eq("drain_empty", 32'(last_instr_valid), 32'd0);

    // Redirect with two requests outstanding.
    apply_reset("rst2");
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 32'h100);
    check_eq("redir_req_valid", 32'(last_req_valid), 32'd0);
    check_eq("redir_instr_valid", 32'(last_instr_valid), 32'd0);
    cycle(1, 1, 1, 0, 0);
    check_eq("flush1_req_valid", 32'(last_req_valid), 32'd0);
    check_eq("flush1_instr_valid", 32'(last_instr_valid), 32'd0);
    cycle(1, 1, 1, 0, 0);
    check_eq("flush2_req_valid", 32'(last_req_valid), 32'd0);
    cycle(1, 1, 1, 0, 0);
    check_eq("post_flush_req_valid", 32'(last_req_valid), 32'd1);
    check_eq("post_flush_req_addr", last_req_addr, 32'h100);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 0);
    check_eq("redir_n_pop", n_pop, 3);

    // Redirect together with a ready head and an arriving response.
    apply_reset("rst3");
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(0, 1, 1, 1, 32'h200);
    check_eq("coinc_instr_valid", 32'(last_instr_valid), 32'd0);
    cycle(0, 1, 1, 0, 0);
    check_eq("coinc_empty_next", 32'(last_instr_valid), 32'd0);
    check_eq("coinc_req_valid", 32'(last_req_valid), 32'd1);
    check_eq("coinc_req_addr", last_req_addr, 32'h200);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 0);
    check_eq("coinc_n_pop", n_pop, 2);

    // Address wrap past 0xFFFF_FFFC.
    apply_reset("rst4");
    cycle(1, 1, 1, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) cycle(1, 1, 1, 0, 0);
    check_eq("wrap_n_req", n_req, 6);
    check_eq("wrap_n_pop", n_pop, 4);
    check_eq("wrap_next_pc", exp_instr_pc, 32'h8);

    // Reset with three queued entries and one in flight.
    apply_reset("rst5");
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, 0);
    check_eq("pre_rst_instr_valid", 32'(instr_valid), 32'd1);
    check_eq("pre_rst_n_req", n_req, 4);
    apply_reset("midrst");
    cycle(1, 0, 1, 0, 0);
    check_eq("midrst_first_valid", 32'(last_req_valid), 32'd1);
    check_eq("midrst_first_addr", last_req_addr, 32'h0);
    for (int i = 0; i < 7; i++) cycle(1, 0, 1, 0, 0);
    check_eq("midrst_n_req", n_req, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
